scene_scroller: RTL and testbench
=================================

# scene_scroller

Parametrised multi-layer scrolling scene renderer for the VGA pixel path. Renders LAYERS horizontally wrapping background strips with per-layer parallax, a speed that ramps during play, and a centred game-over overlay. Drives synchronous image ROM ports and returns one 12-bit RGB pixel per clock, with fixed latency behind the pixel coordinates. Sits between the VGA timing generator and the sprite mixer; the game FSM provides `game_state`.

## Interface
- `LAYERS`, 2: number of scrolling strips (1..4); layer 0 is nearest.
- `IMG_W`, 1200: strip image width in pixels; must be ≥ 640.
- `LAYER_H`, 15: strip height in rows.
- `LAYER_Y`, 20: top row of layer 0.
- `LAYER_STEP`, 15: row pitch between successive layer tops; overlap is allowed.
- `ADDR_W`, 16: ROM address width.
- `SPEED_INIT`, 3: layer-0 pixels per tick when play starts.
- `SPEED_MAX`, 12: speed ceiling.
- `ACCEL_TICKS`, 500: ticks between speed increments.
- `GO_X`, 223 / `GO_Y`, 200 / `GO_W`, 193 / `GO_H`, 13: overlay placement and size.
- `KEY`, 12'h000: transparent colour key for layers and overlay.
- `BG`, 12'hFFF: background colour.
- `clk` in 1: pixel clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `tick` in 1: one-cycle scroll strobe (100 Hz), synchronous to `clk`.
- `game_state` in 2: 0 INITIAL, 1 PLAYING, 2 OVER, 3 treated as OVER.
- `x` in 10, `y` in 9, `de` in 1: pixel coordinate and display enable.
- `layer_addr` out LAYERS*ADDR_W: per-layer ROM address; layer k is in slice k.
- `layer_data` in LAYERS*12: ROM read data, one cycle after the address.
- `go_addr` out ADDR_W, `go_data` in 12: overlay ROM port.
- `data` out 12: output pixel.
- `de_out` out 1: `de` delayed to align with `data`.
- `speed` out 5: current layer-0 speed.

## Operation
- Per-layer offset `off[k]` is in 0..IMG_W-1. Layer k speed is `speed >> k`, with a minimum of 1 while PLAYING.
- On `tick`:
  - INITIAL: all offsets are 0, `speed` is SPEED_INIT, and the accel counter is 0.
  - PLAYING: `off[k] ← off[k]+s_k`; if the result is ≥ IMG_W, subtract IMG_W. The accel counter increments. When it reaches ACCEL_TICKS-1 it clears, and `speed` increments, saturating at SPEED_MAX.
  - OVER: everything holds.
- When speed and offset update on the same tick, the offset uses the old speed.
- When `tick` is low, the scroll state holds in every game state.
- Pixel fetch for layer k:
  - The layer is hit when `y` is in [LAYER_Y+k*LAYER_STEP, +LAYER_H).
  - `xr = x+off[k]`, minus IMG_W if ≥ IMG_W; `yr` = row within the layer.
  - `addr = yr*IMG_W + xr`. On a miss the address is 0.
- Overlay is hit when `x-GO_X < GO_W` and `y-GO_Y < GO_H`, using unsigned 16-bit differences. Overlay address is `(y-GO_Y)*GO_W + (x-GO_X)`.
- Pixel priority, highest first:
  1. Overlay, if OVER and hit and `go_data ≠ KEY`.
  2. Lowest-index hit layer whose data ≠ KEY, if `game_state ≠ INITIAL`.
  3. `BG`.
- When the delayed `de` is 0, `data` is `BG`.
- Hit flags and `game_state` are pipelined alongside the addresses so that the selection uses values from the same pixel.

## Timing
- Stage 1 (edge E0): capture `x`/`y`/`de`; register `layer_addr`, `go_addr` and the hit flags.
- Stage 2 (E1): the ROM returns data; hit flags and `de` advance one stage.
- Stage 3 (E2): `data` and `de_out` are registered.
- Latency is 3 clocks from the `x`/`y` input to `data`; throughput is one pixel per clock.
- The scroll offset used for a pixel is the value at E0. A tick lands mid-line without extra masking.
- Reset values: `data` = BG, `de_out` = 0, `layer_addr` = 0, `go_addr` = 0, `speed` = SPEED_INIT, offsets = 0, accel counter = 0, pipeline flags = 0.
- Reset mid-frame: outputs take their reset values immediately and asynchronously. After `rst_n` releases, valid pixels resume on the third edge.
- Wrap boundary: with `off` = IMG_W-1 and x = 1, `xr` = 0, never IMG_W.

## Test plan
- Reset and INITIAL: assert `rst_n`=0 mid-line. Expect `data`=FFF, `de_out`=0 and `speed`=3 asynchronously. In INITIAL, row 25 outputs FFF, because layers are hidden.
- Latency and addressing: PLAYING with offsets 0, present x=100, y=22. Expect `layer_addr[0]`=2*1200+100=2500 after E0 and `data`=ROM value 3 clocks later. With `de`=0, expect FFF.
- Wrap: force `off[0]`=1197, speed 3, one tick. Expect `off[0]`=0; then x=5, y=20 gives address 5.
- Parallax and ramp: LAYERS=2, ACCEL_TICKS=4, play 4 ticks. Expect `off[0]`=12 and `off[1]`=4 (3>>1=1 per tick); `speed` becomes 4 after the 4th tick. Ramp stops at 12.
- Priority: set OVER with x=223, y=200. Overlay data 0F0 gives `data`=0F0. Overlay data = KEY falls through to a layer or FFF. Overlapping layers where layer 0 = KEY show layer 1.
- Freeze: switch PLAYING→OVER. Offsets and speed hold across 10 ticks; returning to INITIAL zeroes them on the next tick.

Source files
------------

// File: rtl/scene_scroller.sv
// scene_scroller: parallax strip renderer for the VGA pixel path.
// Three-stage pixel pipeline: address/hit capture, ROM read, colour select.
// Each strip owns its scroll offset and address generator (scene_layer).

module scene_layer #(
  parameter int K          = 0,
  parameter int IMG_W      = 1200,
  parameter int LAYER_H    = 15,
  parameter int LAYER_Y    = 20,
  parameter int LAYER_STEP = 15,
  parameter int ADDR_W     = 16,
  parameter int OFF_W      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              play,
  input  logic              init,
  input  logic [4:0]        speed,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              hit
);
  localparam logic [OFF_W:0] IMG_WL = (OFF_W+1)'(IMG_W);
  localparam logic [9:0]     TOP    = 10'(LAYER_Y + K*LAYER_STEP);
  localparam logic [9:0]     BOT    = 10'(LAYER_Y + K*LAYER_STEP + LAYER_H);

  logic [OFF_W-1:0]  off;
  logic [4:0]        step;
  logic [OFF_W:0]    off_sum;
  logic [OFF_W:0]    x_sum;
  logic [OFF_W:0]    xr;
  logic [9:0]        yc;
  logic [9:0]        yr;
  logic              hit_d;
  logic [ADDR_W-1:0] addr_d;

  // Layer speed (parallax shift, floor of 1) and the wrapped next offset
  always_comb begin
    step = speed >> K;
    if (step == '0) step = 5'd1;
    off_sum = {1'b0, off} + (OFF_W+1)'(step);
  end

  // Scroll offset: zeroed in INITIAL, advanced in PLAYING, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off <= '0;
    end else if (tick) begin
      if (init)
        off <= '0;
      else if (play)
        off <= (off_sum >= IMG_WL) ? OFF_W'(off_sum - IMG_WL) : OFF_W'(off_sum);
    end
  end

  // Row hit and ROM address; x+off wraps once since off < IMG_W and x < IMG_W
  always_comb begin
    x_sum  = (OFF_W+1)'(x) + {1'b0, off};
    xr     = (x_sum >= IMG_WL) ? x_sum - IMG_WL : x_sum;
    yc     = {1'b0, y};
    hit_d  = (yc >= TOP) && (yc < BOT);
    yr     = yc - TOP;
    addr_d = hit_d ? ADDR_W'(yr) * ADDR_W'(IMG_W) + ADDR_W'(xr) : '0;
  end

  // Stage-1 address and hit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      hit  <= 1'b0;
    end else begin
      addr <= addr_d;
      hit  <= hit_d;
    end
  end
endmodule

module scene_scroller #(
  parameter int          LAYERS      = 2,
  parameter int          IMG_W       = 1200,
  parameter int          LAYER_H     = 15,
  parameter int          LAYER_Y     = 20,
  parameter int          LAYER_STEP  = 15,
  parameter int          ADDR_W      = 16,
  parameter int          SPEED_INIT  = 3,
  parameter int          SPEED_MAX   = 12,
  parameter int          ACCEL_TICKS = 500,
  parameter int          GO_X        = 223,
  parameter int          GO_Y        = 200,
  parameter int          GO_W        = 193,
  parameter int          GO_H        = 13,
  parameter logic [11:0] KEY         = 12'h000,
  parameter logic [11:0] BG          = 12'hFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [1:0]               game_state,
  input  logic [9:0]               x,
  input  logic [8:0]               y,
  input  logic                     de,
  output logic [LAYERS*ADDR_W-1:0] layer_addr,
  input  logic [LAYERS*12-1:0]     layer_data,
  output logic [ADDR_W-1:0]        go_addr,
  input  logic [11:0]              go_data,
  output logic [11:0]              data,
  output logic                     de_out,
  output logic [4:0]               speed
);
  localparam int OFF_W  = $clog2(IMG_W);
  localparam int CNT_W  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam int STAGES = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_TICKS - 1);

  typedef enum logic [1:0] {
    GS_INIT     = 2'd0,
    GS_PLAY     = 2'd1,
    GS_OVER     = 2'd2,
    GS_OVER_ALT = 2'd3
  } gs_e;

  gs_e                           gs, gs_s1, gs_s2;
  logic                          play, init;
  logic [CNT_W-1:0]              accel;
  logic [LAYERS-1:0][ADDR_W-1:0] addr_s1;
  logic [LAYERS-1:0]             hit_s1, hit_s2;
  logic [LAYERS-1:0][11:0]       ld;
  logic [STAGES:0]               vld_pipe;
  logic [15:0]                   gdx, gdy;
  logic                          go_hit_d, go_hit_s1, go_hit_s2;
  logic [ADDR_W-1:0]             go_addr_d;
  logic                          over_s2;
  logic [11:0]                   pix_d;

  assign gs         = gs_e'(game_state);
  assign play       = (gs == GS_PLAY);
  assign init       = (gs == GS_INIT);
  assign layer_addr = addr_s1;
  assign ld         = layer_data;
  assign de_out     = vld_pipe[STAGES];

  // Speed ramp: offsets sample the old speed on the same tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed <= 5'(SPEED_INIT);
      accel <= '0;
    end else if (tick) begin
      if (init) begin
        speed <= 5'(SPEED_INIT);
        accel <= '0;
      end else if (play) begin
        if (accel == CNT_LAST) begin
          accel <= '0;
          if (speed < 5'(SPEED_MAX)) speed <= speed + 5'd1;
        end else begin
          accel <= accel + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    scene_layer #(
      .K(k), .IMG_W(IMG_W), .LAYER_H(LAYER_H), .LAYER_Y(LAYER_Y),
      .LAYER_STEP(LAYER_STEP), .ADDR_W(ADDR_W), .OFF_W(OFF_W)
    ) u_layer (
      .clk(clk), .rst_n(rst_n), .tick(tick), .play(play), .init(init),
      .speed(speed), .x(x), .y(y), .addr(addr_s1[k]), .hit(hit_s1[k])
    );
  end

  // Overlay window test; unsigned wrap makes left/above coordinates miss
  always_comb begin
    gdx       = 16'(x) - 16'(GO_X);
    gdy       = 16'(y) - 16'(GO_Y);
    go_hit_d  = (gdx < 16'(GO_W)) && (gdy < 16'(GO_H));
    go_addr_d = go_hit_d ? ADDR_W'(gdy) * ADDR_W'(GO_W) + ADDR_W'(gdx) : '0;
  end

  // Sideband pipeline: de, hits and game state travel with the ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      go_addr   <= '0;
      go_hit_s1 <= 1'b0;
      go_hit_s2 <= 1'b0;
      hit_s2    <= '0;
      gs_s1     <= GS_INIT;
      gs_s2     <= GS_INIT;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], de};
      go_addr   <= go_addr_d;
      go_hit_s1 <= go_hit_d;
      go_hit_s2 <= go_hit_s1;
      hit_s2    <= hit_s1;
      gs_s1     <= gs;
      gs_s2     <= gs_s1;
    end
  end

  // Colour select: overlay, then nearest opaque layer, then background
  always_comb begin
    pix_d   = BG;
    over_s2 = (gs_s2 == GS_OVER) || (gs_s2 == GS_OVER_ALT);
    if (vld_pipe[STAGES-1]) begin
      if (over_s2 && go_hit_s2 && go_data != KEY) begin
        pix_d = go_data;
      end else if (gs_s2 != GS_INIT) begin
        for (int k = LAYERS-1; k >= 0; k--)
          if (hit_s2[k] && ld[k] != KEY) pix_d = ld[k];
      end
    end
  end

  // Stage-3 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= BG;
    else        data <= pix_d;
  end
endmodule

// File: tb/tb_scene_scroller.sv
// Directed bench for scene_scroller with a ROM model and an expected-pixel queue.
module tb_scene_scroller;
  localparam int LAYERS = 2, IMG_W = 1200, LAYER_H = 15, LAYER_Y = 20;
  localparam int LAYER_STEP = 10, ADDR_W = 16, ACCEL = 4;

  typedef struct packed { logic de; logic [11:0] d; } exp_t;

  logic clk = 0, rst_n = 0, tick = 0, de = 0;
  logic [1:0] game_state = 0;
  logic [9:0] x = 0;
  logic [8:0] y = 0;
  logic [LAYERS*ADDR_W-1:0] layer_addr;
  logic [LAYERS*12-1:0] layer_data;
  logic [ADDR_W-1:0] go_addr;
  logic [11:0] go_data, data;
  logic de_out;
  logic [4:0] speed;

  bit key_l0 = 0, go_key = 0;
  int off_m[LAYERS];
  int spd_m = 3, cnt_m = 0;
  int n_cmp = 0, n_err = 0;
  exp_t q[$];

  scene_scroller #(
    .LAYERS(LAYERS), .IMG_W(IMG_W), .LAYER_H(LAYER_H), .LAYER_Y(LAYER_Y),
    .LAYER_STEP(LAYER_STEP), .ADDR_W(ADDR_W), .SPEED_INIT(3), .SPEED_MAX(12),
    .ACCEL_TICKS(ACCEL), .GO_X(223), .GO_Y(200), .GO_W(193), .GO_H(13),
    .KEY(12'h000), .BG(12'hFFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .game_state(game_state),
    .x(x), .y(y), .de(de), .layer_addr(layer_addr), .layer_data(layer_data),
    .go_addr(go_addr), .go_data(go_data), .data(data), .de_out(de_out),
    .speed(speed)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_l(input int k, input logic [15:0] a);
    if (key_l0 && k == 0) return 12'h000;
    return {4'(k + 1), a[7:0]};
  endfunction

  function automatic logic [11:0] rom_go(input logic [15:0] a);
    if (go_key) return 12'h000;
    if (a == 16'd0) return 12'h0F0;
    return {4'h5, a[7:0]};
  endfunction

  // synchronous ROMs: one cycle from address to data
  always @(posedge clk) begin
    for (int k = 0; k < LAYERS; k++)
      layer_data[k*12 +: 12] <= rom_l(k, layer_addr[k*ADDR_W +: ADDR_W]);
    go_data <= rom_go(go_addr);
  end

  function automatic bit l_hit(input int k, input int yi);
    int top = LAYER_Y + k*LAYER_STEP;
    return (yi >= top) && (yi < top + LAYER_H);
  endfunction

  function automatic int l_addr(input int k, input int xi, input int yi);
    int xr;
    if (!l_hit(k, yi)) return 0;
    xr = xi + off_m[k];
    if (xr >= IMG_W) xr -= IMG_W;
    return (yi - (LAYER_Y + k*LAYER_STEP)) * IMG_W + xr;
  endfunction

  function automatic bit go_hit(input int xi, input int yi);
    return (xi >= 223) && (xi < 223 + 193) && (yi >= 200) && (yi < 200 + 13);
  endfunction

  function automatic int go_a(input int xi, input int yi);
    return (yi - 200) * 193 + (xi - 223);
  endfunction

  function automatic logic [11:0] exp_pix(input int xi, input int yi, input bit dei, input int gs);
    logic [11:0] d;
    if (!dei) return 12'hFFF;
    if (gs >= 2 && go_hit(xi, yi)) begin
      d = rom_go(16'(go_a(xi, yi)));
      if (d != 12'h000) return d;
    end
    if (gs != 0)
      for (int k = 0; k < LAYERS; k++)
        if (l_hit(k, yi)) begin
          d = rom_l(k, 16'(l_addr(k, xi, yi)));
          if (d != 12'h000) return d;
        end
    return 12'hFFF;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LAYERS; k++) off_m[k] = 0;
    spd_m = 3;
    cnt_m = 0;
  endtask

  task automatic model_tick(input int gs);
    int s;
    if (gs == 0) begin
      model_reset();
    end else if (gs == 1) begin
      for (int k = 0; k < LAYERS; k++) begin
        s = spd_m >> k;
        if (s < 1) s = 1;
        off_m[k] += s;
        if (off_m[k] >= IMG_W) off_m[k] -= IMG_W;
      end
      if (cnt_m == ACCEL - 1) begin
        cnt_m = 0;
        if (spd_m < 12) spd_m++;
      end else begin
        cnt_m++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // one pixel clock: drive, predict, then check addresses now and the pixel from 3 clocks back
  task automatic step(input int xi, input int yi, input bit dei, input bit ti);
    exp_t e;
    int a0, a1, ga;
    bit gh;
    x = 10'(xi); y = 9'(yi); de = dei; tick = ti;
    e.de = dei;
    e.d  = exp_pix(xi, yi, dei, int'(game_state));
    a0 = l_addr(0, xi, yi);
    a1 = l_addr(1, xi, yi);
    gh = go_hit(xi, yi);
    ga = gh ? go_a(xi, yi) : 0;
    if (ti) model_tick(int'(game_state));
    q.push_back(e);
    @(posedge clk); #1;
    tick = 0;
    chk("layer_addr0", 32'(layer_addr[0 +: ADDR_W]), 32'(a0));
    chk("layer_addr1", 32'(layer_addr[ADDR_W +: ADDR_W]), 32'(a1));
    if (gh) chk("go_addr", 32'(go_addr), 32'(ga));
    chk("speed", 32'(speed), 32'(spd_m));
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("de_out", 32'(de_out), 32'(e.de));
      chk("data", 32'(data), 32'(e.d));
    end
  endtask

  task automatic flush();
    repeat (2) step(0, 0, 0, 0);
  endtask

  initial begin
    int wx, sv;
    model_reset();
    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 32'hFFF);
    chk("rst_de_out", 32'(de_out), 32'h0);
    chk("rst_speed", 32'(speed), 32'd3);
    chk("rst_layer_addr", 32'(layer_addr), 32'h0);
    chk("rst_go_addr", 32'(go_addr), 32'h0);
    rst_n = 1;

    // INITIAL: layers hidden, ticks keep everything at zero
    game_state = 2'd0;
    step(100, 25, 1, 1);
    step(101, 25, 1, 0);
    step(102, 22, 1, 1);
    step(103, 25, 1, 0);

    // PLAYING, offsets 0: address and latency
    game_state = 2'd1;
    step(100, 22, 1, 0);
    chk("addr_2500", 32'(layer_addr[0 +: ADDR_W]), 32'd2500);
    step(100, 22, 0, 0);
    step(5, 30, 1, 0);

    // parallax and ramp
    repeat (4) step(0, 20, 1, 1);
    chk("speed_after_4", 32'(speed), 32'd4);
    step(0, 20, 1, 0);
    chk("off0_12", 32'(layer_addr[0 +: ADDR_W]), 32'd12);
    step(0, 30, 1, 0);
    chk("off1_4", 32'(layer_addr[ADDR_W +: ADDR_W]), 32'd4);

    // long run: saturation, offset wrap, x+off wrap boundary
    for (int i = 0; i < 126; i++) begin
      step(1, 20, 1, 1);
      wx = (off_m[0] >= 561) ? IMG_W - off_m[0] : 639;
      step(wx, 20, 1, 0);
      step(wx - 1, 20, 1, 0);
      step(1, 30, 1, 0);
    end
    chk("speed_sat", 32'(speed), 32'd12);

    // asynchronous reset mid-line
    repeat (3) step(100, 22, 1, 0);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_data", 32'(data), 32'hFFF);
    chk("mid_rst_de_out", 32'(de_out), 32'h0);
    chk("mid_rst_speed", 32'(speed), 32'd3);
    chk("mid_rst_layer_addr", 32'(layer_addr), 32'h0);
    chk("mid_rst_go_addr", 32'(go_addr), 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    q.delete();
    repeat (4) step(100, 22, 1, 0);

    // priority in OVER
    flush();
    game_state = 2'd2;
    step(223, 200, 1, 0);
    step(415, 212, 1, 0);
    step(416, 212, 1, 0);
    step(223, 213, 1, 0);
    step(222, 200, 1, 0);
    step(100, 22, 1, 0);
    flush();
    go_key = 1;
    step(223, 200, 1, 0);
    step(300, 205, 1, 0);
    flush();
    key_l0 = 1;
    step(50, 30, 1, 0);
    step(50, 25, 1, 0);
    step(50, 40, 1, 0);
    flush();
    key_l0 = 0;
    go_key = 0;
    game_state = 2'd3;
    step(223, 200, 1, 0);
    step(60, 30, 1, 0);

    // freeze in OVER, then INITIAL clears on the next tick
    game_state = 2'd1;
    repeat (5) step(1, 20, 1, 1);
    game_state = 2'd2;
    sv = spd_m;
    repeat (10) step(1, 20, 1, 1);
    chk("freeze_speed", 32'(speed), 32'(sv));
    step(1, 30, 1, 0);
    game_state = 2'd0;
    step(1, 20, 1, 1);
    step(0, 20, 1, 0);
    chk("init_off0", 32'(layer_addr[0 +: ADDR_W]), 32'd0);
    chk("init_speed", 32'(speed), 32'd3);
    repeat (3) step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
